// File: rtl/benes_pkg.sv
// Shared Benes network geometry: stage/bit-count derivation, column strides and switch pairing.
// Also used by the upstream control-bit generator so both agree on ctrl ordering.
package benes_pkg;

  localparam int unsigned LANE_W = 32;

  typedef logic [LANE_W-1:0] lane_t;

  // Number of switch columns for a network with 2^tagwidth lanes.
  function automatic int unsigned stages_of(input int unsigned tagwidth);
    return 2 * tagwidth - 1;
  endfunction

  // Width of the full control vector (one bit per switch).
  function automatic int unsigned bitwidth_of(input int unsigned size);
    return stages_of($clog2(size)) * (size / 2);
  endfunction

  // Column k pairs lanes 2^min(k, STAGES-1-k) apart.
  function automatic int unsigned stage_stride(input int unsigned k, input int unsigned tagwidth);
    int unsigned stages;
    int unsigned m;
    stages = stages_of(tagwidth);
    m      = (k < stages - 1 - k) ? k : stages - 1 - k;
    return 32'd1 << m;
  endfunction

  // Lower lane of switch j: the j-th ascending index whose stride bit is clear.
  function automatic int unsigned pair_lo(input int unsigned j, input int unsigned stride);
    return (j / stride) * (2 * stride) + (j % stride);
  endfunction

  // Bit offset of stage k's residual ctrl slice in a triangularly packed vector.
  function automatic int unsigned res_off(input int unsigned k, input int unsigned stages,
                                          input int unsigned half);
    return half * (k * (stages - 1) - (k * (k - 1)) / 2);
  endfunction

endpackage

// File: rtl/benes_column.sv
// One combinational column of SIZE/2 conditional-swap switches at a fixed lane stride.
module benes_column
  import benes_pkg::*;
#(
  parameter int unsigned SIZE   = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned STRIDE = 1
) (
  input  logic [SIZE*DATA_W-1:0] data_in,
  input  logic [SIZE/2-1:0]      ctrl,
  output logic [SIZE*DATA_W-1:0] data_out
);

  for (genvar j = 0; j < SIZE / 2; j++) begin : g_sw
    localparam int unsigned LO = pair_lo(j, STRIDE);
    localparam int unsigned HI = LO + STRIDE;

    assign data_out[LO*DATA_W +: DATA_W] = ctrl[j] ? data_in[HI*DATA_W +: DATA_W]
                                                   : data_in[LO*DATA_W +: DATA_W];
    assign data_out[HI*DATA_W +: DATA_W] = ctrl[j] ? data_in[LO*DATA_W +: DATA_W]
                                                   : data_in[HI*DATA_W +: DATA_W];
  end

endmodule

// File: rtl/benes_xbar_pipe.sv
// Pipelined Benes permutation datapath with one register per switch column and valid/ready flow.
// Define BENES_OUT_SKID_EN to add a 2-entry output skid FIFO that cuts out_ready -> in_ready.
module benes_xbar_pipe
  import benes_pkg::*;
#(
  parameter int unsigned SIZE   = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   flush,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [SIZE*DATA_W-1:0]                 in_data,
  input  logic [bitwidth_of(SIZE)-1:0]           in_ctrl,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [SIZE*DATA_W-1:0]                 out_data,
  output logic                                   busy
);

  localparam int unsigned TAGWIDTH = $clog2(SIZE);
  localparam int unsigned STAGES   = stages_of(TAGWIDTH);
  localparam int unsigned BITWIDTH = bitwidth_of(SIZE);
  localparam int unsigned HALF     = SIZE / 2;
  localparam int unsigned LANES_W  = SIZE * DATA_W;
  localparam int unsigned RES_W    = res_off(STAGES - 1, STAGES, HALF);

  logic [STAGES-1:0]  valid_s;
  logic [STAGES-1:0]  ready_s;
  logic [LANES_W-1:0] data_s [STAGES];
  logic [RES_W-1:0]   res_s;
  logic               tail_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned STRIDE = stage_stride(k, TAGWIDTH);
    localparam int unsigned RW     = (STAGES - 1 - k) * HALF;

    logic [LANES_W-1:0] col_in;
    logic [LANES_W-1:0] col_out;
    logic [HALF-1:0]    col_ctrl;
    logic               up_valid;
    logic               valid_q;
    logic [LANES_W-1:0] data_q;

    if (k == 0) begin : g_src
      assign col_in   = in_data;
      assign col_ctrl = in_ctrl[HALF-1:0];
      assign up_valid = in_valid;
    end else begin : g_src
      assign col_in   = data_s[k-1];
      assign col_ctrl = res_s[res_off(k - 1, STAGES, HALF) +: HALF];
      assign up_valid = valid_s[k-1];
    end

    benes_column #(
      .SIZE   (SIZE),
      .DATA_W (DATA_W),
      .STRIDE (STRIDE)
    ) u_col (
      .data_in  (col_in),
      .ctrl     (col_ctrl),
      .data_out (col_out)
    );

    // A stage is ready when empty or when everything downstream can advance.
    assign ready_s[k] = tail_ready | ~(&valid_s[STAGES-1:k]);

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        data_q  <= '0;
      end else if (flush) begin
        valid_q <= 1'b0;
      end else if (ready_s[k]) begin
        valid_q <= up_valid;
        data_q  <= col_out;
      end
    end

    assign valid_s[k] = valid_q;
    assign data_s[k]  = data_q;

    // Residual ctrl for columns after this one; the last stage carries none.
    if (k < STAGES - 1) begin : g_res
      logic [RW-1:0] res_in;
      logic [RW-1:0] res_q;

      if (k == 0) begin : g_first
        assign res_in = in_ctrl[BITWIDTH-1:HALF];
      end else begin : g_next
        assign res_in = res_s[res_off(k - 1, STAGES, HALF) + HALF +: RW];
      end

      always_ff @(posedge clk) begin
        if (ready_s[k]) begin
          res_q <= res_in;
        end
      end

      assign res_s[res_off(k, STAGES, HALF) +: RW] = res_q;
    end
  end

  assign in_ready = ready_s[0];
  assign busy     = |valid_s;

`ifdef BENES_OUT_SKID_EN
  logic [LANES_W-1:0] skid_mem [2];
  logic               wr_ptr;
  logic               rd_ptr;
  logic [1:0]         skid_cnt;
  logic               push;
  logic               pop;

  assign tail_ready = (skid_cnt != 2'd2);
  assign push       = valid_s[STAGES-1] & tail_ready;
  assign pop        = (skid_cnt != 2'd0) & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      skid_mem[0] <= '0;
      skid_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      skid_cnt    <= 2'd0;
    end else if (flush) begin
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      skid_cnt    <= 2'd0;
    end else begin
      if (push) begin
        skid_mem[wr_ptr] <= data_s[STAGES-1];
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      skid_cnt <= skid_cnt + 2'(push) - 2'(pop);
    end
  end

  assign out_valid = (skid_cnt != 2'd0);
  assign out_data  = skid_mem[rd_ptr];
`else
  assign tail_ready = out_ready;
  assign out_valid  = valid_s[STAGES-1];
  assign out_data   = data_s[STAGES-1];
`endif

endmodule
